imem_loader: RTL and testbench

- Boot-time writer for the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles the bytes into Dbits-wide words.
- Each finished word is written into sequential imem word locations 0..Nloc-1.
- The processor is held in reset while a load is in progress.
- It sits between the serial/debug byte source and the write port of the writable instruction memory, and produces a running XOR checksum for host-side confirmation.

---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 131 +++++++++++++
 tb/tb_imem_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and imem write-port bundle for the boot-time instruction memory loader.
// Byte handshake: a byte moves on a rising edge where rx_valid and rx_ready are both high;
// the source keeps rx_data stable and rx_valid high until that edge, and rx_ready never depends on rx_valid.
interface imem_loader_if #(
    parameter int Dbits = 32,
    parameter int Abits = 5
);
    logic             start;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_ready;
    logic             imem_we;
    logic [Abits-1:0] imem_addr;
    logic [Dbits-1:0] imem_wdata;
    logic             cpu_hold;
    logic             busy;
    logic             done;
    logic [Dbits-1:0] checksum;
    logic [1:0]       state_dbg;

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, checksum, state_dbg
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, checksum, state_dbg
    );
endinterface

// File: rtl/imem_loader.sv
// Assembles an MSB-first byte stream into Dbits-wide words and writes them to imem
// addresses 0..Nloc-1 while holding the CPU in reset; keeps an XOR checksum of the session.
module imem_loader #(
    parameter int Nloc  = 32,
    parameter int Dbits = 32,
    parameter int Abits = 5
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);
    localparam int NB = Dbits / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0]    LAST_BYTE = BW'(NB - 1);
    localparam logic [Abits-1:0] LAST_WORD = Abits'(Nloc - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [Abits-1:0] word_cnt_q, word_cnt_d;
    logic [Dbits-1:0] word_q, word_d;
    logic [Dbits-1:0] checksum_q, checksum_d;
    logic [Abits-1:0] imem_addr_q, imem_addr_d;
    logic [Dbits-1:0] imem_wdata_q, imem_wdata_d;
    logic             rx_ready_q, rx_ready_d;
    logic             imem_we_q, imem_we_d;
    logic             busy_q, busy_d;
    logic             cpu_hold_q, cpu_hold_d;
    logic             done_q, done_d;
    logic             hs;

    // rx_ready is a registered copy of "in RECV", so the handshake never loops back combinationally.
    assign hs = rx_ready_q & bus.rx_valid;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        word_d       = word_q;
        checksum_d   = checksum_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d    = S_RECV;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    checksum_d = '0;
                end
            end
            S_RECV: begin
                if (hs) begin
                    word_d = (word_q << 8) | Dbits'(bus.rx_data);
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d   = '0;
                        state_d      = S_WRITE;
                        imem_addr_d  = word_cnt_q;
                        imem_wdata_d = word_d;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end
                end
            end
            S_WRITE: begin
                checksum_d = checksum_q ^ word_q;
                if (word_cnt_q == LAST_WORD) begin
                    state_d = S_DONE;
                end else begin
                    word_cnt_d = word_cnt_q + Abits'(1);
                    state_d    = S_RECV;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered: decode them from the state being entered.
        rx_ready_d = (state_d == S_RECV);
        imem_we_d  = (state_d == S_WRITE);
        busy_d     = (state_d == S_RECV) || (state_d == S_WRITE);
        cpu_hold_d = busy_d;
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            word_q       <= '0;
            checksum_q   <= '0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            busy_q       <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            word_q       <= word_d;
            checksum_q   <= checksum_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            busy_q       <= busy_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.busy       = busy_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.done       = done_q;
    assign bus.checksum   = checksum_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a word-level model predicts the write sequence and checksum.
module tb_imem_loader;
  localparam int NLOC  = 4;
  localparam int DBITS = 32;
  localparam int ABITS = 5;
  localparam int NB    = DBITS / 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [ABITS+DBITS-1:0] exp_q[$];
  logic [DBITS-1:0]       model_sum;
  int                     next_addr;
  int                     t_start;

  imem_loader_if #(.Dbits(DBITS), .Abits(ABITS)) bus ();

  imem_loader #(.Nloc(NLOC), .Dbits(DBITS), .Abits(ABITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (bus.imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 64'(bus.imem_addr), 64'hFFFF);
      end else begin
        logic [ABITS+DBITS-1:0] e;
        e = exp_q.pop_front();
        check("we_addr", 64'(bus.imem_addr), 64'(e[ABITS+DBITS-1:DBITS]));
        check("we_data", 64'(bus.imem_wdata), 64'(e[DBITS-1:0]));
        check("we_rx_ready", 64'(bus.rx_ready), 64'd0);
      end
    end
  end

  // driver tasks; inputs change 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int t;
    gap = $urandom_range(max_gap, 0);
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) tick();
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    t = 0;
    while (!bus.rx_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check("handshake_timeout", 64'(t), 64'd0);
    tick();
  endtask

  task automatic expect_word(input logic [DBITS-1:0] w);
    exp_q.push_back({ABITS'(next_addr), w});
    model_sum ^= w;
    next_addr++;
  endtask

  task automatic send_word(input logic [DBITS-1:0] w, input int max_gap);
    expect_word(w);
    for (int i = NB - 1; i >= 0; i--) send_byte(w[8*i +: 8], max_gap);
  endtask

  task automatic begin_session();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    t_start   = cyc;
    model_sum = '0;
    next_addr = 0;
    check("start_done", 64'(bus.done), 64'd0);
    check("start_sum", 64'(bus.checksum), 64'd0);
    check("start_busy", 64'(bus.busy), 64'd1);
    check("start_hold", 64'(bus.cpu_hold), 64'd1);
    check("start_ready", 64'(bus.rx_ready), 64'd1);
  endtask

  task automatic end_session(input bit check_time);
    int t;
    bus.rx_valid = 1'b0;
    t = 0;
    while (!bus.done && t < 400) begin
      tick();
      t++;
    end
    if (t >= 400) check("done_timeout", 64'(t), 64'd0);
    if (check_time) check("load_cycles", 64'(cyc - t_start), 64'(NLOC * (NB + 1)));
    check("end_done", 64'(bus.done), 64'd1);
    check("end_busy", 64'(bus.busy), 64'd0);
    check("end_hold", 64'(bus.cpu_hold), 64'd0);
    check("end_ready", 64'(bus.rx_ready), 64'd0);
    check("end_sum", 64'(bus.checksum), 64'(model_sum));
    check("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [DBITS-1:0] w;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    model_sum    = '0;
    next_addr    = 0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    check("idle_ready", 64'(bus.rx_ready), 64'd0);
    check("idle_we", 64'(bus.imem_we), 64'd0);
    check("idle_hold", 64'(bus.cpu_hold), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_done", 64'(bus.done), 64'd0);
    check("idle_sum", 64'(bus.checksum), 64'd0);

    // single known word, then random fill
    begin_session();
    send_word(32'h2008_0005, 0);
    for (int i = 1; i < NLOC; i++) send_word($urandom, 0);
    end_session(1'b1);

    // back-to-back power-of-two words: checksum all ones, exact cycle count
    begin_session();
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    send_word(32'h4444_4444, 0);
    send_word(32'h8888_8888, 0);
    end_session(1'b1);
    check("pow2_sum", 64'(bus.checksum), 64'hFFFF_FFFF);

    // same words with random gaps
    begin_session();
    send_word(32'h1111_1111, 3);
    send_word(32'h2222_2222, 3);
    send_word(32'h4444_4444, 3);
    send_word(32'h8888_8888, 3);
    end_session(1'b0);
    check("gap_sum", 64'(bus.checksum), 64'hFFFF_FFFF);

    // reset after two words and two bytes
    begin_session();
    send_word($urandom, 2);
    send_word($urandom, 2);
    w = $urandom;
    send_byte(w[31:24], 2);
    send_byte(w[23:16], 2);
    bus.rx_valid = 1'b0;
    check("mid_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_hold", 64'(bus.cpu_hold), 64'd0);
    check("rst_ready", 64'(bus.rx_ready), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_sum", 64'(bus.checksum), 64'd0);
    check("rst_sb", 64'(exp_q.size()), 64'd0);
    repeat (6) tick();
    begin_session();
    send_word(32'hDEAD_BEEF, 1);
    for (int i = 1; i < NLOC; i++) send_word($urandom, 1);
    end_session(1'b0);

    // start pulsed mid-word is ignored
    begin_session();
    send_word($urandom, 1);
    w = $urandom;
    expect_word(w);
    send_byte(w[31:24], 1);
    send_byte(w[23:16], 1);
    bus.rx_valid = 1'b0;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    check("ign_busy", 64'(bus.busy), 64'd1);
    send_byte(w[15:8], 1);
    send_byte(w[7:0], 1);
    for (int i = 2; i < NLOC; i++) send_word($urandom, 1);
    end_session(1'b0);

    // restart directly from DONE, a few random sessions
    for (int s = 0; s < 4; s++) begin
      begin_session();
      for (int i = 0; i < NLOC; i++) send_word($urandom, 3);
      end_session(1'b0);
    end

    repeat (3) tick();
    check("final_sb", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
